run_controller: RTL and testbench

- Bench-side and board-side counterpart to TopLevel's run/trace interface.
- Drives TopLevel's start pulse and waits for halt.
- Counts run cycles and branches; enforces a timeout watchdog.
- Captures every register and memory write TopLevel reports into a trace FIFO, drained through a valid/ready port.

---
 rtl/run_controller.sv | 158 +++++++++++++++
 tb/tb_run_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_controller: sequences a TopLevel run, counts cycles/branches, traces writes
// into a FWFT FIFO. Optional macro TRACE_BRANCH_EN also traces branches. Rev 1.0
// ---------------------------------------------------------------------------
module run_controller #(
  parameter int PC_W       = 8,
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          go,
  output logic                          start,
  input  logic                          halt,
  input  logic                          REG_WRITE,
  input  logic [REG_W-1:0]              write_register,
  input  logic [DATA_W-1:0]             regWriteValue,
  input  logic                          MEM_WRITE,
  input  logic [DATA_W-1:0]             memWriteValue,
  input  logic [PC_W-1:0]               PC,
  input  logic                          BRANCH,
  output logic                          busy,
  output logic                          done,
  output logic                          timed_out,
  output logic [15:0]                   cycle_count,
  output logic [15:0]                   branch_count,
  output logic                          trace_valid,
  output logic [2+REG_W+PC_W+DATA_W-1:0] trace_data,
  input  logic                          trace_ready,
  output logic [7:0]                    trace_drops
);
  localparam int TD_W = 2 + REG_W + PC_W + DATA_W;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cyc_q, cyc_d, br_q, br_d, cyc_inc;
  logic              to_q, to_d;
  logic [7:0]        drops_q, drops_d;
  logic [8:0]        drops_sum;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [TD_W-1:0]   mem_q [FIFO_DEPTH];

  logic              empty, full, pop, push_req, push, in_run;
  logic [1:0]        kind, drop_inc;
  logic [REG_W-1:0]  ev_reg;
  logic [DATA_W-1:0] ev_val;

  always_comb begin
    kind   = 2'b00;
    ev_reg = '0;
    ev_val = '0;
    if (REG_WRITE) begin
      kind   = 2'b01;
      ev_reg = write_register;
      ev_val = regWriteValue;
    end else if (MEM_WRITE) begin
      kind   = 2'b10;
      ev_val = memWriteValue;
    end
`ifdef TRACE_BRANCH_EN
    else if (BRANCH) begin
      kind = 2'b11;
    end
`endif
  end

  always_comb begin
    in_run   = (state_q == S_RUN);
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    pop      = !empty && trace_ready;
    push_req = in_run && (kind != 2'b00);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push     = push_req && (!full || pop);
    drop_inc = {1'b0, in_run && REG_WRITE && MEM_WRITE} + {1'b0, push_req && !push};
    drops_sum = {1'b0, drops_q} + {7'b0, drop_inc};
    cyc_inc  = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    br_d    = br_q;
    to_d    = to_q;
    drops_d = drops_q;
    wr_d    = wr_q + {{AW{1'b0}}, push};
    rd_d    = rd_q + {{AW{1'b0}}, pop};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_START;
          cyc_d   = '0;
          br_d    = '0;
          to_d    = 1'b0;
          drops_d = '0;
          wr_d    = '0;
          rd_d    = '0;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        cyc_d   = cyc_inc;
        drops_d = drops_sum[8] ? 8'hFF : drops_sum[7:0];
        if (BRANCH && (br_q != 16'hFFFF)) br_d = br_q + 16'd1;
        // cyc_q==0 marks the first RUN cycle, where a stale halt is masked.
        if (halt && (cyc_q != 16'd0)) begin
          state_d = S_DONE;
        end else if (cyc_inc == TO_CNT) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      br_q    <= '0;
      to_q    <= 1'b0;
      drops_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      br_q    <= br_d;
      to_q    <= to_d;
      drops_q <= drops_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {kind, ev_reg, PC, ev_val};
  end

  assign start        = (state_q == S_START);
  assign busy         = (state_q == S_START) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign timed_out    = to_q;
  assign cycle_count  = cyc_q;
  assign branch_count = br_q;
  assign trace_valid  = !empty;
  assign trace_data   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign trace_drops  = drops_q;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_controller: directed scenarios plus random runs against a queue-based
// reference model of run_controller. Rev 1.0
// ---------------------------------------------------------------------------
module tb_run_controller;
  localparam int TO    = 48;
  localparam int DEPTH = 8;
  localparam int PH_IDLE = 0, PH_START = 1, PH_RUN = 2, PH_DONE = 3;

  logic        CLK = 1'b0;
  logic        RST_N, go, halt, REG_WRITE, MEM_WRITE, BRANCH, trace_ready;
  logic [3:0]  write_register;
  logic [15:0] regWriteValue, memWriteValue;
  logic [7:0]  PC;
  logic        start, busy, done, timed_out, trace_valid;
  logic [15:0] cycle_count, branch_count;
  logic [29:0] trace_data;
  logic [7:0]  trace_drops;

  run_controller #(.PC_W(8), .DATA_W(16), .REG_W(4), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .go(go), .start(start), .halt(halt),
    .REG_WRITE(REG_WRITE), .write_register(write_register), .regWriteValue(regWriteValue),
    .MEM_WRITE(MEM_WRITE), .memWriteValue(memWriteValue), .PC(PC), .BRANCH(BRANCH),
    .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count),
    .branch_count(branch_count), .trace_valid(trace_valid), .trace_data(trace_data),
    .trace_ready(trace_ready), .trace_drops(trace_drops)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  int ph = PH_IDLE, m_cc = 0, m_bc = 0, m_to = 0, m_drops = 0;
  logic [29:0] mq[$];
  int start_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model one cycle from the current inputs, clock the DUT, compare.
  task automatic step();
    int n;
    if (!RST_N) begin
      ph = PH_IDLE; m_cc = 0; m_bc = 0; m_to = 0; m_drops = 0; mq.delete();
    end else if ((ph == PH_IDLE || ph == PH_DONE) && go) begin
      ph = PH_START; m_cc = 0; m_bc = 0; m_to = 0; m_drops = 0; mq.delete();
    end else begin
      bit do_pop = (mq.size() > 0) && trace_ready;
      if (do_pop) void'(mq.pop_front());
      if (ph == PH_START) begin
        ph = PH_RUN;
      end else if (ph == PH_RUN) begin
        n = 0;
        if (REG_WRITE || MEM_WRITE) begin
          if (mq.size() < DEPTH)
            mq.push_back(REG_WRITE ? {2'b01, write_register, PC, regWriteValue}
                                   : {2'b10, 4'h0, PC, memWriteValue});
          else n++;
          if (REG_WRITE && MEM_WRITE) n++;
        end
`ifdef TRACE_BRANCH_EN
        else if (BRANCH) begin
          if (mq.size() < DEPTH) mq.push_back({2'b11, 4'h0, PC, 16'h0});
          else n++;
        end
`endif
        m_drops = (m_drops + n > 255) ? 255 : m_drops + n;
        m_cc = (m_cc < 65535) ? m_cc + 1 : m_cc;
        if (BRANCH && m_bc < 65535) m_bc++;
        if (halt && m_cc >= 2) ph = PH_DONE;
        else if (m_cc == TO) begin ph = PH_DONE; m_to = 1; end
      end
    end
    @(posedge CLK);
    #1;
    if (start) start_seen++;
    check("start", start, ph == PH_START);
    check("busy", busy, ph == PH_START || ph == PH_RUN);
    check("done", done, ph == PH_DONE);
    check("timed_out", timed_out, m_to);
    check("cycle_count", cycle_count, m_cc);
    check("branch_count", branch_count, m_bc);
    check("trace_valid", trace_valid, mq.size() > 0);
    check("trace_data", trace_data, (mq.size() > 0) ? mq[0] : 30'h0);
    check("trace_drops", trace_drops, m_drops);
  endtask

  task automatic quiet();
    go = 0; halt = 0; REG_WRITE = 0; MEM_WRITE = 0; BRANCH = 0;
    write_register = 0; regWriteValue = 0; memWriteValue = 0; PC = 0;
  endtask

  task automatic launch();
    go = 1; step();
    go = 0; step();
  endtask

  initial begin
    int k, drained, halt_mod;
    RST_N = 0; trace_ready = 0; quiet();
    step(); step();
    check("reset_busy", busy, 0);
    check("reset_cc", cycle_count, 0);
    RST_N = 1;
    step();

    // Basic run: halt on the 40th RUN cycle, branch every third cycle.
    start_seen = 0;
    launch();
    for (k = 1; k <= 40; k++) begin
      halt = (k == 40); BRANCH = (k % 3 == 0);
      step();
    end
    quiet();
    check("basic_start_pulses", start_seen, 1);
    check("basic_done", done, 1);
    check("basic_cc", cycle_count, 40);
    check("basic_bc", branch_count, 13);
    check("basic_to", timed_out, 0);
    step();
    check("basic_cc_hold", cycle_count, 40);

    // Stale halt held through go, START and RUN cycle 1.
    halt = 1; go = 1; step();
    go = 0; step();
    step();
    check("stale_masked", busy, 1);
    halt = 0; step(); step(); step();
    halt = 1; step();
    halt = 0;
    check("stale_done", done, 1);
    check("stale_cc", cycle_count, 5);

    // Timeout with no halt.
    launch();
    k = 0;
    while (!done && k < TO + 10) begin BRANCH = $urandom_range(0, 1); step(); k++; end
    quiet();
    check("timeout_flag", timed_out, 1);
    check("timeout_cc", cycle_count, TO);

    // Trace ordering and first-word-fall-through latency.
    trace_ready = 0;
    launch();
    check("trace_empty_pre", trace_valid, 0);
    REG_WRITE = 1; write_register = 4'h3; regWriteValue = 16'h00AB; PC = 8'h05; step();
    check("trace_lat0", trace_valid, 1);
    check("trace_e0", trace_data, {2'b01, 4'h3, 8'h05, 16'h00AB});
    quiet(); MEM_WRITE = 1; memWriteValue = 16'h1234; PC = 8'h06; step();
    quiet(); trace_ready = 1; halt = 1; step();
    check("trace_e1", trace_data, {2'b10, 4'h0, 8'h06, 16'h1234});
    quiet(); step();
    check("trace_drained", trace_valid, 0);

    // Overflow: 10 writes into an 8-deep FIFO, then full push with pop.
    trace_ready = 0;
    launch();
    for (k = 0; k < 10; k++) begin
      REG_WRITE = 1; write_register = 4'(k); regWriteValue = 16'(k * 17); PC = 8'(k);
      step();
    end
    check("ovf_drops", trace_drops, 2);
    trace_ready = 1; regWriteValue = 16'hBEEF; step();
    check("ovf_fullpop_nodrop", trace_drops, 2);
    quiet(); halt = 1; step();
    halt = 0; drained = 0;
    for (k = 0; k < 20; k++) begin
      if (trace_valid) drained++;
      step();
    end
    check("ovf_drain", drained, 7);

    // Collision then reset mid-run.
    trace_ready = 0;
    launch();
    REG_WRITE = 1; MEM_WRITE = 1; write_register = 4'h5; regWriteValue = 16'h5555;
    memWriteValue = 16'hAAAA; PC = 8'h10; step();
    quiet();
    check("coll_drops", trace_drops, 1);
    check("coll_kind", {30'h0, trace_data[29:28]}, 2'b01);
    BRANCH = 1; step();
    RST_N = 0; step();
    check("rst_busy", busy, 0);
    check("rst_valid", trace_valid, 0);
    check("rst_cc", cycle_count, 0);
    check("rst_bc", branch_count, 0);
    check("rst_drops", trace_drops, 0);
    RST_N = 1; quiet();

    // Random traffic.
    halt_mod = 24;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) halt_mod = $urandom_range(4, 80);
      RST_N          = ($urandom_range(0, 399) != 0);
      go             = ($urandom_range(0, 7) == 0);
      halt           = ($urandom_range(0, halt_mod - 1) == 0);
      REG_WRITE      = ($urandom_range(0, 2) == 0);
      MEM_WRITE      = ($urandom_range(0, 2) == 0);
      BRANCH         = $urandom_range(0, 1);
      trace_ready    = ($urandom_range(0, 3) != 0);
      write_register = 4'($urandom);
      regWriteValue  = 16'($urandom);
      memWriteValue  = 16'($urandom);
      PC             = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
